// File: rtl/synth_pkg.sv
// Shared types and constants for the time-multiplexed voice sequencer.
package synth_pkg;

    localparam int unsigned PHASE_W        = 24;
    localparam int unsigned WAVE_W         = 24;
    localparam int unsigned GEN_PHASE_W    = 12;
    localparam int unsigned NUM_VOICES_DEF = 4;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StAccum,
        StDone
    } seq_state_e;

    typedef enum logic [1:0] {
        WaveSine,
        WaveSaw,
        WaveSquare,
        WaveTriangle
    } wave_sel_e;

    typedef struct packed {
        logic [PHASE_W-1:0] inc;
        wave_sel_e          sel;
        logic               en;
    } voice_cfg_t;

endpackage

// File: rtl/voice_cfg_regs.sv
// Per-voice configuration: shadow set written at any time, active set copied on pass start.
module voice_cfg_regs
    import synth_pkg::*;
#(
    parameter int unsigned NUM_VOICES = NUM_VOICES_DEF,
    localparam int unsigned VW        = $clog2(NUM_VOICES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_cfg_we,
    input  logic [VW-1:0]      i_cfg_voice,
    input  logic [PHASE_W-1:0] i_cfg_inc,
    input  logic [1:0]         i_cfg_sel,
    input  logic               i_cfg_en,
    input  logic               i_copy,
    input  logic [VW-1:0]      i_rd_voice,
    output voice_cfg_t         o_rd_cfg
);

    voice_cfg_t r_shadow [NUM_VOICES];
    voice_cfg_t r_active [NUM_VOICES];
    voice_cfg_t w_wr_cfg;

    always_comb begin
        w_wr_cfg.inc = i_cfg_inc;
        w_wr_cfg.sel = wave_sel_e'(i_cfg_sel);
        w_wr_cfg.en  = i_cfg_en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (i_cfg_we && (i_cfg_voice == VW'(i))) begin
                    r_shadow[i] <= w_wr_cfg;
                end
                // A write landing on the copy edge bypasses the shadow so it takes effect now.
                if (i_copy) begin
                    r_active[i] <= (i_cfg_we && (i_cfg_voice == VW'(i))) ? w_wr_cfg : r_shadow[i];
                end
            end
        end
    end

    assign o_rd_cfg = r_active[i_rd_voice];

endmodule

// File: rtl/voice_sequencer.sv
// Time-multiplexed voice sequencer: walks voices through a shared waveform generator
// once per sample tick, advancing phases and averaging the enabled voices into mix_out.
module voice_sequencer
    import synth_pkg::*;
#(
    parameter int unsigned NUM_VOICES = NUM_VOICES_DEF,
    parameter int unsigned GEN_LAT    = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sample_tick,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_VOICES)-1:0] cfg_voice,
    input  logic [PHASE_W-1:0]            cfg_inc,
    input  logic [1:0]                    cfg_sel,
    input  logic                          cfg_en,
    output logic [GEN_PHASE_W-1:0]        gen_phase,
    output logic [1:0]                    gen_sel,
    input  logic signed [WAVE_W-1:0]      gen_wave,
    output logic signed [WAVE_W-1:0]      mix_out,
    output logic                          mix_valid,
    output logic                          busy,
    output logic                          overrun
);

    localparam int unsigned VW    = $clog2(NUM_VOICES);
    localparam int unsigned ACC_W = WAVE_W + VW;

    seq_state_e              r_state;
    logic [VW-1:0]           r_voice;
    logic [7:0]              r_wait;
    logic [PHASE_W-1:0]      r_phase [NUM_VOICES];
    logic signed [ACC_W-1:0] r_acc;
    logic signed [WAVE_W-1:0] r_mix_stage;
    logic signed [WAVE_W-1:0] r_mix;
    logic                    r_pend;
    logic                    r_valid;
    logic                    r_overrun;

    voice_cfg_t              w_cfg;
    logic                    w_start;
    logic                    w_last;
    logic signed [ACC_W-1:0] w_wave_ext;

    assign w_start    = (r_state == StIdle) && sample_tick;
    assign w_last     = (r_voice == VW'(NUM_VOICES - 1));
    assign w_wave_ext = $signed({{VW{gen_wave[WAVE_W-1]}}, gen_wave});

    voice_cfg_regs #(
        .NUM_VOICES (NUM_VOICES)
    ) u_cfg_regs (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_cfg_we    (cfg_we),
        .i_cfg_voice (cfg_voice),
        .i_cfg_inc   (cfg_inc),
        .i_cfg_sel   (cfg_sel),
        .i_cfg_en    (cfg_en),
        .i_copy      (w_start),
        .i_rd_voice  (r_voice),
        .o_rd_cfg    (w_cfg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_voice     <= '0;
            r_wait      <= '0;
            r_acc       <= '0;
            r_mix_stage <= '0;
            r_mix       <= '0;
            r_pend      <= 1'b0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_phase[i] <= '0;
            end
        end else begin
            // The averaged sample is presented one cycle after the pass leaves DONE.
            r_pend  <= 1'b0;
            r_valid <= r_pend;
            if (r_pend) begin
                r_mix <= r_mix_stage;
            end
            if (sample_tick && (r_state != StIdle)) begin
                r_overrun <= 1'b1;
            end
            unique case (r_state)
                StIdle: begin
                    if (sample_tick) begin
                        r_state <= StIssue;
                        r_voice <= '0;
                    end
                end
                StIssue: begin
                    r_state <= StWait;
                    r_wait  <= '0;
                end
                StWait: begin
                    if (r_wait == 8'(GEN_LAT - 1)) begin
                        r_state <= StAccum;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                StAccum: begin
                    if (w_cfg.en) begin
                        r_acc            <= r_acc + w_wave_ext;
                        r_phase[r_voice] <= r_phase[r_voice] + w_cfg.inc;
                    end
                    if (w_last) begin
                        r_state <= StDone;
                    end else begin
                        r_voice <= r_voice + VW'(1);
                        r_state <= StIssue;
                    end
                end
                StDone: begin
                    r_mix_stage <= WAVE_W'(r_acc >>> VW);
                    r_acc       <= '0;
                    r_pend      <= 1'b1;
                    r_state     <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_comb begin
        gen_phase = '0;
        gen_sel   = '0;
        if (r_state inside {StIssue, StWait, StAccum}) begin
            gen_phase = r_phase[r_voice][PHASE_W-1:PHASE_W-GEN_PHASE_W];
            gen_sel   = w_cfg.sel;
        end
    end

    assign mix_out   = r_mix;
    assign mix_valid = r_valid;
    assign busy      = (r_state != StIdle);
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_voice_sequencer.sv
// Self-checking bench for voice_sequencer: vector table, directed corner sequences,
// and randomized passes checked against a pass-level behavioural model.
module tb_voice_sequencer;

    localparam int NV  = 4;
    localparam int LAT = NV * (2 + 1) + 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_tick = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_voice = '0;
    logic [23:0] cfg_inc = '0;
    logic [1:0]  cfg_sel = '0;
    logic        cfg_en = 1'b0;
    logic [11:0] gen_phase;
    logic [1:0]  gen_sel;
    logic signed [23:0] gen_wave;
    logic signed [23:0] mix_out;
    logic        mix_valid;
    logic        busy;
    logic        overrun;

    always #5 clk = ~clk;

    voice_sequencer #(
        .NUM_VOICES (NV),
        .GEN_LAT    (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .cfg_we      (cfg_we),
        .cfg_voice   (cfg_voice),
        .cfg_inc     (cfg_inc),
        .cfg_sel     (cfg_sel),
        .cfg_en      (cfg_en),
        .gen_phase   (gen_phase),
        .gen_sel     (gen_sel),
        .gen_wave    (gen_wave),
        .mix_out     (mix_out),
        .mix_valid   (mix_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    // Generator stub: constant, or a one-cycle-latency function of phase and select.
    function automatic logic signed [23:0] wave_fn(input logic [11:0] p, input logic [1:0] s);
        return {p ^ {s, 10'h0}, s, 10'h15A};
    endfunction

    logic               gen_mode = 1'b0;
    logic signed [23:0] stub_const = '0;
    logic signed [23:0] stub_q = '0;
    always @(posedge clk) stub_q <= wave_fn(gen_phase, gen_sel);
    assign gen_wave = gen_mode ? stub_q : stub_const;

    // Model state: shadow config and per-voice phases.
    logic [23:0] sh_inc [NV];
    logic [1:0]  sh_sel [NV];
    logic        sh_en  [NV];
    logic [23:0] m_phase [NV];
    logic [11:0] exp_ph [NV];
    logic [1:0]  exp_sel [NV];
    logic signed [23:0] exp_mix;

    logic [11:0] cap_ph [NV];
    logic [1:0]  cap_sel [NV];
    int          last_lat;
    logic signed [23:0] last_mix;

    logic        co_wr = 1'b0, mid_wr = 1'b0;
    logic [1:0]  co_v, mid_v, co_sel, mid_sel;
    logic [23:0] co_inc, mid_inc;
    logic        co_en, mid_en;
    int          mid_k;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int v = 0; v < NV; v++) begin
            sh_inc[v] = '0; sh_sel[v] = '0; sh_en[v] = 1'b0; m_phase[v] = '0;
        end
    endtask

    task automatic model_write(input logic [1:0] v, input logic [23:0] inc,
                               input logic [1:0] sel, input logic en);
        sh_inc[v] = inc; sh_sel[v] = sel; sh_en[v] = en;
    endtask

    // One pass: snapshot config, sum enabled voices' waves, average, advance phases.
    task automatic model_pass();
        longint sum;
        logic signed [23:0] w;
        sum = 0;
        for (int v = 0; v < NV; v++) begin
            exp_ph[v]  = m_phase[v][23:12];
            exp_sel[v] = sh_sel[v];
            if (sh_en[v]) begin
                w = gen_mode ? wave_fn(m_phase[v][23:12], sh_sel[v]) : stub_const;
                sum += w;
                m_phase[v] = m_phase[v] + sh_inc[v];
            end
        end
        exp_mix = 24'(sum >>> 2);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; sample_tick = 1'b0; cfg_we = 1'b0;
        co_wr = 1'b0; mid_wr = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        model_clear();
    endtask

    task automatic cfg_write(input logic [1:0] v, input logic [23:0] inc,
                             input logic [1:0] sel, input logic en);
        cfg_we = 1'b1; cfg_voice = v; cfg_inc = inc; cfg_sel = sel; cfg_en = en;
        cyc();
        cfg_we = 1'b0;
        model_write(v, inc, sel, en);
    endtask

    task automatic run_pass();
        sample_tick = 1'b1;
        if (co_wr) begin
            cfg_we = 1'b1; cfg_voice = co_v; cfg_inc = co_inc; cfg_sel = co_sel; cfg_en = co_en;
        end
        cyc();
        sample_tick = 1'b0;
        cfg_we = 1'b0;
        if (co_wr) model_write(co_v, co_inc, co_sel, co_en);
        co_wr = 1'b0;
        model_pass();
        last_lat = -1;
        last_mix = '0;
        for (int k = 1; k <= 40; k++) begin
            if (((k - 1) % 3 == 0) && (k <= 3 * NV)) begin
                cap_ph[(k - 1) / 3]  = gen_phase;
                cap_sel[(k - 1) / 3] = gen_sel;
            end
            if (mid_wr && (k == mid_k)) begin
                cfg_we = 1'b1; cfg_voice = mid_v; cfg_inc = mid_inc;
                cfg_sel = mid_sel; cfg_en = mid_en;
            end
            cyc();
            if (mid_wr && (k == mid_k)) begin
                cfg_we = 1'b0;
                model_write(mid_v, mid_inc, mid_sel, mid_en);
                mid_wr = 1'b0;
            end
            if (mix_valid) begin
                last_lat = k;
                last_mix = mix_out;
                break;
            end
        end
    endtask

    typedef struct {
        logic [3:0]         en_mask;
        logic signed [23:0] wave;
        logic signed [23:0] mix;
    } vec_t;

    vec_t        vecs [7];
    logic [11:0] exp_seq [3];
    int          nvalid;

    initial begin
        vecs[0] = '{4'b0001, 24'sh400000, 24'sh100000};
        vecs[1] = '{4'b1111, 24'sh800000, 24'sh800000};
        vecs[2] = '{4'b1111, 24'sh7FFFFF, 24'sh7FFFFF};
        vecs[3] = '{4'b0000, 24'sh123456, 24'sh000000};
        vecs[4] = '{4'b0011, 24'sh000004, 24'sh000002};
        vecs[5] = '{4'b1101, 24'shFFFFFD, 24'shFFFFFD};
        vecs[6] = '{4'b0100, 24'shFFFFFF, 24'shFFFFFF};

        // Reset state
        do_reset();
        check("rst_mix_out", mix_out, 0);
        check("rst_mix_valid", mix_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_gen_phase", gen_phase, 0);
        check("rst_gen_sel", gen_sel, 0);

        // Vector table: enable pattern and constant wave against hand-computed averages
        for (int i = 0; i < 7; i++) begin
            do_reset();
            stub_const = vecs[i].wave;
            for (int v = 0; v < NV; v++) begin
                cfg_write(2'(v), 24'h010000 * (v + 1), 2'(v), vecs[i].en_mask[v]);
            end
            run_pass();
            check($sformatf("vec%0d_latency", i), last_lat, LAT);
            check($sformatf("vec%0d_mix", i), last_mix, vecs[i].mix);
            cyc();
            check($sformatf("vec%0d_valid_pulse", i), mix_valid, 0);
        end

        // Phase stepping on voice 0, then wrap-around at half-scale increment
        do_reset();
        stub_const = 24'sh400000;
        cfg_write(2'd0, 24'h100000, 2'd1, 1'b1);
        exp_seq = '{12'h000, 12'h100, 12'h200};
        for (int t = 0; t < 3; t++) begin
            run_pass();
            check($sformatf("step_ph%0d", t), cap_ph[0], exp_seq[t]);
            check($sformatf("step_sel%0d", t), cap_sel[0], 2'd1);
            check($sformatf("step_mix%0d", t), last_mix, 24'h100000);
        end
        do_reset();
        cfg_write(2'd0, 24'h800000, 2'd0, 1'b1);
        exp_seq = '{12'h000, 12'h800, 12'h000};
        for (int t = 0; t < 3; t++) begin
            run_pass();
            check($sformatf("wrap_ph%0d", t), cap_ph[0], exp_seq[t]);
        end

        // Tick while busy: ignored, overrun sticky, single mix_valid, next tick normal
        do_reset();
        stub_const = 24'sh000100;
        cfg_write(2'd0, 24'h001000, 2'd2, 1'b1);
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        model_pass();
        repeat (4) cyc();
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        check("ovr_set", overrun, 1);
        nvalid = 0;
        for (int k = 0; k < 30; k++) begin
            if (mix_valid) begin
                nvalid++;
                check("ovr_mix", mix_out, exp_mix);
            end
            cyc();
        end
        check("ovr_single_valid", nvalid, 1);
        run_pass();
        check("ovr_next_latency", last_lat, LAT);
        check("ovr_next_mix", last_mix, exp_mix);
        check("ovr_next_ph", cap_ph[0], exp_ph[0]);
        check("ovr_sticky", overrun, 1);

        // Config write during a pass lands next pass; write with the tick lands now
        do_reset();
        stub_const = 24'sh000010;
        cfg_write(2'd0, 24'h100000, 2'd1, 1'b1);
        mid_wr = 1'b1; mid_k = 4; mid_v = 2'd0; mid_inc = 24'h200000; mid_sel = 2'd1; mid_en = 1'b1;
        run_pass();
        check("busywr_p1", cap_ph[0], 12'h000);
        run_pass();
        check("busywr_p2", cap_ph[0], 12'h100);
        run_pass();
        check("busywr_p3", cap_ph[0], 12'h300);
        co_wr = 1'b1; co_v = 2'd0; co_inc = 24'h400000; co_sel = 2'd3; co_en = 1'b1;
        run_pass();
        check("bypass_p4_ph", cap_ph[0], 12'h500);
        check("bypass_p4_sel", cap_sel[0], 2'd3);
        run_pass();
        check("bypass_p5_ph", cap_ph[0], 12'h900);

        // Reset mid-pass: outputs clear at once, no mix_valid, phases restart at 0
        do_reset();
        stub_const = 24'sh400000;
        cfg_write(2'd0, 24'h100000, 2'd1, 1'b1);
        cfg_write(2'd1, 24'h300000, 2'd2, 1'b1);
        run_pass();
        check("pre_rst_mix", last_mix, 24'h200000);
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        cyc(); cyc();
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        cyc(); cyc();
        check("pre_rst_gen_phase", gen_phase, 12'h300);
        rst_n = 1'b0;
        #1;
        check("midrst_mix_out", mix_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_overrun", overrun, 0);
        check("midrst_gen_phase", gen_phase, 0);
        check("midrst_gen_sel", gen_sel, 0);
        cyc(); cyc();
        rst_n = 1'b1;
        model_clear();
        nvalid = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (mix_valid) nvalid++;
        end
        check("midrst_no_valid", nvalid, 0);
        cfg_write(2'd1, 24'h300000, 2'd2, 1'b1);
        run_pass();
        check("postrst_ph1", cap_ph[1], 12'h000);
        check("postrst_latency", last_lat, LAT);
        check("postrst_mix", last_mix, exp_mix);

        // Randomized passes against the model
        do_reset();
        gen_mode = 1'b1;
        for (int v = 0; v < NV; v++) begin
            cfg_write(2'(v), 24'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        for (int p = 0; p < 25; p++) begin
            if ($urandom_range(0, 3) == 0) begin
                co_wr = 1'b1; co_v = 2'($urandom_range(0, 3)); co_inc = 24'($urandom);
                co_sel = 2'($urandom_range(0, 3)); co_en = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 2) == 0) begin
                mid_wr = 1'b1; mid_k = int'($urandom_range(1, 12));
                mid_v = 2'($urandom_range(0, 3)); mid_inc = 24'($urandom);
                mid_sel = 2'($urandom_range(0, 3)); mid_en = 1'($urandom_range(0, 1));
            end
            run_pass();
            check($sformatf("rnd%0d_latency", p), last_lat, LAT);
            check($sformatf("rnd%0d_mix", p), last_mix, exp_mix);
            for (int v = 0; v < NV; v++) begin
                check($sformatf("rnd%0d_ph%0d", p, v), cap_ph[v], exp_ph[v]);
                check($sformatf("rnd%0d_sel%0d", p, v), cap_sel[v], exp_sel[v]);
            end
            repeat ($urandom_range(0, 2)) cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
